// File: rtl/case_sel_sequencer.sv
// case_sel_sequencer - holds select codes for len+1 beats toward the case decoder
// One active command plus a one-entry pending buffer so commands issue back-to-back.
module case_sel_sequencer #(
    parameter int SEL_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [CNT_W-1:0] in_len,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel_o,
    output logic             last_o,
    output logic             busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [SEL_W-1:0] cur_sel, cur_sel_nx;
    logic [CNT_W-1:0] remaining, remaining_nx;
    logic             pend_valid, pend_valid_nx;
    logic [SEL_W-1:0] pend_sel, pend_sel_nx;
    logic [CNT_W-1:0] pend_len, pend_len_nx;
    logic             accept;
    logic             beat;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready = !pend_valid;
    assign accept   = in_valid & in_ready;
    assign beat     = (state == ACTIVE) & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_sel    <= '0;
            remaining  <= '0;
            pend_valid <= 1'b0;
            pend_sel   <= '0;
            pend_len   <= '0;
        end else begin
            state      <= state_nx;
            cur_sel    <= cur_sel_nx;
            remaining  <= remaining_nx;
            pend_valid <= pend_valid_nx;
            pend_sel   <= pend_sel_nx;
            pend_len   <= pend_len_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cur_sel_nx    = cur_sel;
        remaining_nx  = remaining;
        pend_valid_nx = pend_valid;
        pend_sel_nx   = pend_sel;
        pend_len_nx   = pend_len;

        out_valid = 1'b0;
        sel_o     = '0;
        last_o    = 1'b0;
        busy      = pend_valid;

        case (state)
            IDLE: begin
                if (accept) begin
                    cur_sel_nx   = in_sel;
                    remaining_nx = in_len;
                    state_nx     = ACTIVE;
                end
            end
            ACTIVE: begin
                out_valid = 1'b1;
                sel_o     = cur_sel;
                last_o    = (remaining == '0);
                busy      = 1'b1;
                if (beat && remaining != '0) begin
                    remaining_nx = remaining - 1'b1;
                    if (accept) begin
                        pend_valid_nx = 1'b1;
                        pend_sel_nx   = in_sel;
                        pend_len_nx   = in_len;
                    end
                end else if (beat && pend_valid) begin
                    // accept is impossible here since in_ready is low while pending
                    cur_sel_nx    = pend_sel;
                    remaining_nx  = pend_len;
                    pend_valid_nx = 1'b0;
                end else if (beat && accept) begin
                    cur_sel_nx   = in_sel;
                    remaining_nx = in_len;
                end else if (beat) begin
                    state_nx = IDLE;
                end else if (accept) begin
                    pend_valid_nx = 1'b1;
                    pend_sel_nx   = in_sel;
                    pend_len_nx   = in_len;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Flush wins over every other event, including a same-cycle accept.
        if (abort) begin
            state_nx      = IDLE;
            pend_valid_nx = 1'b0;
        end
    end

endmodule
